sensor_capture_ctrl: RTL and testbench

SENSOR_CAPTURE_CTRL -- requirements
Module: sensor_capture_ctrl

---
 rtl/sensor_ctrl_pkg.sv | 21 ++
 rtl/sensor_capture_ctrl_if.sv | 17 +
 rtl/sensor_capture_ctrl_geom.sv | 85 ++++++++
 rtl/sensor_capture_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sensor_capture_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared types and constants for the sensor capture controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_t       : capture FSM states
//   H/V_ACTIVE_DEF: default frame geometry
//   TO_W          : width of the frame-start timeout counter
package sensor_ctrl_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int TO_W         = 22;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT_VS = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/sensor_capture_ctrl_if.sv
// Captured pixel stream: strobe, frame/line markers and pixel byte.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept every pixel_valid cycle.
//   master: driven by the capture controller
//   slave : pixel consumer
interface sensor_capture_ctrl_if;

    logic       pix_valid;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;
    logic [7:0] pix_data;

    modport master (output pix_valid, pix_sof, pix_eol, pix_eof, pix_data);
    modport slave  (input  pix_valid, pix_sof, pix_eol, pix_eof, pix_data);

endinterface

// File: rtl/sensor_capture_ctrl_geom.sv
// Pixel/line counting, geometry error detection and end-of-line/frame markers.
// Latency: markers are combinational against the 1-cycle-delayed pixel strobe.
// Backpressure: none; follows the sensor syncs.
//   i_en        : capture active (counters held clear otherwise)
//   i_vsync/i_hsync, i_vs_q/i_hs_q : live syncs and their registered copies
//   i_pix_vld_q : registered pixel strobe; o_eol/o_eof align with it
//   i_clr_err   : clears the sticky o_err_geom at run start
//   o_first     : high while both frame counters are at zero
module capture_geom_check
    import sensor_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr_err,
    input  logic i_vsync,
    input  logic i_hsync,
    input  logic i_vs_q,
    input  logic i_hs_q,
    input  logic i_pix_vld_q,
    output logic o_first,
    output logic o_eol,
    output logic o_eof,
    output logic o_err_geom
);

    // One spare count above the nominal value so an over-long line or frame
    // is distinguishable from an exact one.
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 3);

    logic [PW-1:0] r_pix_cnt;
    logic [LW-1:0] r_line_cnt;
    logic          r_err_geom;

    logic          w_pix;
    logic          w_hs_fall;
    logic          w_vs_fall;
    logic          w_h_bad;
    logic          w_v_bad;
    logic [LW-1:0] w_lines;

    assign w_pix     = i_en && i_vsync && i_hsync;
    assign w_hs_fall = i_en && i_hs_q && !i_hsync;
    assign w_vs_fall = i_en && i_vs_q && !i_vsync;
    // A line ending on the same cycle as the frame still counts toward it.
    assign w_lines   = r_line_cnt + LW'(w_hs_fall);
    assign w_h_bad   = w_hs_fall && (r_pix_cnt != PW'(H_ACTIVE));
    assign w_v_bad   = w_vs_fall && (w_lines != LW'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_err_geom <= 1'b0;
        end else begin
            if (!i_en || w_vs_fall) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
            end else if (w_hs_fall) begin
                r_pix_cnt <= '0;
                if (r_line_cnt != LW'(V_ACTIVE + 1))
                    r_line_cnt <= r_line_cnt + LW'(1);
            end else if (w_pix && (r_pix_cnt != PW'(H_ACTIVE + 1))) begin
                r_pix_cnt <= r_pix_cnt + PW'(1);
            end

            if (i_clr_err)
                r_err_geom <= 1'b0;
            else if (w_h_bad || w_v_bad)
                r_err_geom <= 1'b1;
        end
    end

    assign o_first    = (r_pix_cnt == '0) && (r_line_cnt == '0);
    // The pixel on the output is the last of its line when hsync has dropped now.
    assign o_eol      = i_pix_vld_q && !i_hsync;
    // Line counter has not yet advanced for the line that is ending.
    assign o_eof      = o_eol && (r_line_cnt == LW'(V_ACTIVE - 1));
    assign o_err_geom = r_err_geom;

endmodule

// File: rtl/sensor_capture_ctrl.sv
// Sensor capture run controller: arms the sensor, captures N frames, flags timeouts/geometry errors.
// Latency: pixel in -> pix_valid/pix_data out is exactly 1 cycle.
// Backpressure: none; pixels are forwarded every cycle the sensor presents them.
//   cmd_start/cmd_stop/cfg_frames : run control; sensor_start : sensor run enable
//   p_vsync/p_hsync/p_data/sensor_img : sensor side
//   pix (master) : captured stream; busy/done/frame_cnt/last_img/err_* : status
module sensor_capture_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_start,
    input  logic                         cmd_stop,
    input  logic [7:0]                   cfg_frames,
    output logic                         sensor_start,
    input  logic                         p_vsync,
    input  logic                         p_hsync,
    input  logic [7:0]                   p_data,
    input  logic [3:0]                   sensor_img,
    sensor_capture_ctrl_if.master        pix,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   frame_cnt,
    output logic [3:0]                   last_img,
    output logic                         err_timeout,
    output logic                         err_geom
);

    state_t          r_state;
    state_t          w_next;
    logic            r_vs_q;
    logic            r_hs_q;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_cfg;
    logic [7:0]      r_frame_cnt;
    logic [3:0]      r_last_img;
    logic            r_err_to;
    logic            r_stop_pend;
    logic            r_pix_vld;
    logic            r_pix_sof;
    logic [7:0]      r_pix_dat;

    logic            w_start_ok;
    logic            w_vs_rise;
    logic            w_vs_fall;
    logic            w_to_hit;
    logic            w_waiting;
    logic            w_capture;
    logic            w_pix_in;
    logic            w_last_frame;
    logic            w_first;

    assign w_start_ok = (r_state == S_IDLE) && cmd_start && !cmd_stop;
    assign w_vs_rise  = p_vsync && !r_vs_q;
    assign w_vs_fall  = !p_vsync && r_vs_q;
    assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_waiting  = (r_state == S_ARM) || (r_state == S_WAIT_VS);
    assign w_capture  = (r_state == S_CAPTURE);
    assign w_pix_in   = w_capture && p_vsync && p_hsync;
    // A stop arriving on the frame's closing cycle still ends the run there.
    assign w_last_frame = ((r_cfg != 8'd0) && (({1'b0, r_frame_cnt} + 9'd1) == {1'b0, r_cfg}))
                        || r_stop_pend || cmd_stop;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_next = S_ARM;
            S_ARM:     if (cmd_stop || w_to_hit) w_next = S_DONE;
                       else if (!p_vsync)        w_next = S_WAIT_VS;
            S_WAIT_VS: if (cmd_stop || w_to_hit) w_next = S_DONE;
                       else if (w_vs_rise)       w_next = S_CAPTURE;
            S_CAPTURE: if (w_vs_fall) w_next = w_last_frame ? S_DONE : S_WAIT_VS;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sensor_start = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_ARM, S_WAIT_VS, S_CAPTURE: begin
                sensor_start = 1'b1;
                busy         = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_q      <= 1'b0;
            r_hs_q      <= 1'b0;
            r_to_cnt    <= '0;
            r_cfg       <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_last_img  <= 4'd0;
            r_err_to    <= 1'b0;
            r_stop_pend <= 1'b0;
            r_pix_vld   <= 1'b0;
            r_pix_sof   <= 1'b0;
            r_pix_dat   <= 8'd0;
        end else begin
            r_vs_q <= p_vsync;
            r_hs_q <= p_hsync;

            // Every state change restarts the budget, so each ARM/WAIT_VS stay is timed on its own.
            if (w_next != r_state)
                r_to_cnt <= '0;
            else if (w_waiting)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_start_ok) begin
                r_cfg       <= cfg_frames;
                r_frame_cnt <= 8'd0;
                r_err_to    <= 1'b0;
                r_stop_pend <= 1'b0;
            end else begin
                if (w_waiting && w_to_hit)
                    r_err_to <= 1'b1;
                if (w_capture && cmd_stop)
                    r_stop_pend <= 1'b1;
                if (w_capture && w_vs_fall && (r_frame_cnt != 8'hFF))
                    r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if ((r_state == S_WAIT_VS) && (w_next == S_CAPTURE))
                r_last_img <= sensor_img;

            r_pix_vld <= w_pix_in;
            r_pix_sof <= w_pix_in && w_first;
            if (w_pix_in)
                r_pix_dat <= p_data;
        end
    end

    capture_geom_check #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_geom (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_capture),
        .i_clr_err   (w_start_ok),
        .i_vsync     (p_vsync),
        .i_hsync     (p_hsync),
        .i_vs_q      (r_vs_q),
        .i_hs_q      (r_hs_q),
        .i_pix_vld_q (r_pix_vld),
        .o_first     (w_first),
        .o_eol       (pix.pix_eol),
        .o_eof       (pix.pix_eof),
        .o_err_geom  (err_geom)
    );

    assign pix.pix_valid = r_pix_vld;
    assign pix.pix_sof   = r_pix_sof;
    assign pix.pix_data  = r_pix_dat;
    assign frame_cnt     = r_frame_cnt;
    assign last_img      = r_last_img;
    assign err_timeout   = r_err_to;

endmodule

// File: tb/tb_sensor_capture_ctrl.sv
// Scoreboard bench for sensor_capture_ctrl with a small 8x4 sensor model.
// Latency: expects each pixel exactly one cycle after the sensor presents it.
// Backpressure: none exercised (the design has none).
module tb_sensor_capture_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst, cmd_start, cmd_stop;
    logic [7:0] cfg_frames;
    logic       sensor_start;
    logic       p_vsync, p_hsync;
    logic [7:0] p_data;
    logic [3:0] sensor_img;
    logic       busy, done, err_timeout, err_geom;
    logic [7:0] frame_cnt;
    logic [3:0] last_img;

    always #5 clk = ~clk;

    sensor_capture_ctrl_if pix();

    sensor_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cfg_frames(cfg_frames), .sensor_start(sensor_start),
        .p_vsync(p_vsync), .p_hsync(p_hsync), .p_data(p_data), .sensor_img(sensor_img),
        .pix(pix), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .last_img(last_img), .err_timeout(err_timeout), .err_geom(err_geom)
    );

    typedef struct packed {
        logic [7:0]  dat;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [31:0] cyc;
    } pexp_t;

    typedef struct packed {
        logic [7:0]  fc;
        logic        eto;
        logic        egeom;
        logic [3:0]  img;
        logic        chk_cyc;
        logic [31:0] cyc;
    } dexp_t;

    pexp_t      pq[$];
    dexp_t      dq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [31:0] cyc = 32'd0;
    int         n_vld = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0;
    logic [7:0] dat_seed = 8'h11;
    logic [3:0] img_seed = 4'h3;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Monitor: pops expectations whenever the DUT presents a pixel or a done pulse.
    always @(negedge clk) begin : monitor
        pexp_t e;
        dexp_t d;
        if (pix.pix_valid) begin
            n_vld++;
            if (pix.pix_sof) n_sof++;
            if (pix.pix_eol) n_eol++;
            if (pix.pix_eof) n_eof++;
            vectors++;
            if (pq.size() == 0) begin
                miscompares++;
                $display("FAIL pix_unexpected: got data %02h at cycle %0d, required no pixel",
                         pix.pix_data, cyc);
            end else begin
                e = pq.pop_front();
                if ({pix.pix_data, pix.pix_sof, pix.pix_eol, pix.pix_eof, cyc} != e) begin
                    miscompares++;
                    $display("FAIL pix: got dat=%02h sof=%b eol=%b eof=%b cyc=%0d, required dat=%02h sof=%b eol=%b eof=%b cyc=%0d",
                             pix.pix_data, pix.pix_sof, pix.pix_eol, pix.pix_eof, cyc,
                             e.dat, e.sof, e.eol, e.eof, e.cyc);
                end
            end
        end
        if (done) begin
            n_done++;
            vectors++;
            if (dq.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
            end else begin
                d = dq.pop_front();
                if ({frame_cnt, err_timeout, err_geom, last_img} != {d.fc, d.eto, d.egeom, d.img}
                    || (d.chk_cyc && (cyc != d.cyc))) begin
                    miscompares++;
                    $display("FAIL done: got fc=%0d eto=%b egeom=%b img=%0d cyc=%0d, required fc=%0d eto=%b egeom=%b img=%0d cyc=%0d",
                             frame_cnt, err_timeout, err_geom, last_img, cyc,
                             d.fc, d.eto, d.egeom, d.img, d.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] frames);
        cmd_start  = 1'b1;
        cfg_frames = frames;
        tick();
        cmd_start  = 1'b0;
        cfg_frames = ~frames;   // must not influence the run already started
    endtask

    task automatic expect_done(input logic [7:0] fc, input logic eto, input logic egeom,
                               input logic [3:0] img, input logic chk_c, input logic [31:0] c);
        dexp_t d;
        d.fc = fc; d.eto = eto; d.egeom = egeom; d.img = img; d.chk_cyc = chk_c; d.cyc = c;
        dq.push_back(d);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (((pq.size() != 0) || (dq.size() != 0)) && (k < 200)) begin
            tick();
            k++;
        end
        tick();
        chk(name, 64'(pq.size() + dq.size()), 64'd0);
    endtask

    task automatic clr_counts();
        n_vld = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0;
    endtask

    // Sensor model: one frame of V lines; optional short line, stop pulse or reset pulse.
    task automatic frame(input bit cap, input int short_line, input int stop_line, input int rst_line);
        bit    c;
        bit    first;
        int    n;
        pexp_t e;
        c = cap;
        first = 1'b1;
        sensor_img = img_seed;
        img_seed = img_seed + 4'd1;
        p_vsync = 1'b0;
        p_hsync = 1'b0;
        repeat (3) tick();
        p_vsync = 1'b1;
        repeat (2) tick();
        for (int l = 0; l < V; l++) begin
            n = (l == short_line) ? H - 1 : H;
            for (int p = 0; p < n; p++) begin
                p_hsync  = 1'b1;
                p_data   = dat_seed;
                dat_seed = dat_seed + 8'd37;
                cmd_stop = (l == stop_line) && (p == 0);
                if (c) begin
                    e.dat = p_data;
                    e.sof = first;
                    e.eol = (p == n - 1);
                    e.eof = (p == n - 1) && (l == V - 1);
                    e.cyc = cyc + 32'd1;
                    pq.push_back(e);
                end
                first = 1'b0;
                tick();
            end
            cmd_stop = 1'b0;
            p_hsync  = 1'b0;
            if (l == rst_line) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                c = 1'b0;
                chk("rst_mid_capture", 64'({sensor_start, busy, done, frame_cnt, last_img,
                    err_timeout, err_geom, pix.pix_valid, pix.pix_sof, pix.pix_eol,
                    pix.pix_eof, pix.pix_data}), 64'd0);
                tick();
            end else begin
                repeat (2) tick();
            end
        end
        p_vsync = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] t0;
        logic [3:0]  e_img;
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_frames = 8'd0;
        p_vsync = 1'b0; p_hsync = 1'b0; p_data = 8'd0; sensor_img = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", 64'({sensor_start, busy, done, frame_cnt, last_img, err_timeout,
            err_geom, pix.pix_valid, pix.pix_sof, pix.pix_eol, pix.pix_eof, pix.pix_data}), 64'd0);

        // Timeout with vsync held low: done 100 cycles after leaving ARM.
        t0 = cyc;
        expect_done(8'd0, 1'b1, 1'b0, 4'd0, 1'b1, t0 + 32'd102);
        start_run(8'd1);
        chk("arm_busy_start", 64'({busy, sensor_start}), 64'd3);
        drain("timeout_drain");
        chk("timeout_flag_held", 64'(err_timeout), 64'd1);
        chk("timeout_idle", 64'({busy, sensor_start}), 64'd0);

        // Two-frame run; cfg_frames changes after start must be ignored.
        clr_counts();
        e_img = img_seed + 4'd1;
        start_run(8'd2);
        chk("timeout_cleared", 64'(err_timeout), 64'd0);
        expect_done(8'd2, 1'b0, 1'b0, e_img, 1'b0, 32'd0);
        frame(1'b1, -1, -1, -1);
        frame(1'b1, -1, -1, -1);
        drain("run2_drain");
        chk("run2_valid", 64'(n_vld), 64'd64);
        chk("run2_sof", 64'(n_sof), 64'd2);
        chk("run2_eol", 64'(n_eol), 64'd8);
        chk("run2_eof", 64'(n_eof), 64'd2);
        chk("run2_done", 64'(n_done), 64'd1);
        chk("run2_fcnt", 64'(frame_cnt), 64'd2);
        chk("run2_sstart", 64'(sensor_start), 64'd0);

        // Start while a frame is in flight: that frame must be skipped.
        clr_counts();
        p_vsync = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < H; p++) begin
                p_hsync    = 1'b1;
                p_data     = dat_seed;
                dat_seed   = dat_seed + 8'd37;
                cmd_start  = (l == 0) && (p == 3);
                cfg_frames = 8'd1;
                tick();
            end
            cmd_start = 1'b0;
            p_hsync   = 1'b0;
            repeat (2) tick();
        end
        expect_done(8'd1, 1'b0, 1'b0, img_seed, 1'b0, 32'd0);
        frame(1'b1, -1, -1, -1);
        drain("midframe_drain");
        chk("midframe_valid", 64'(n_vld), 64'd32);

        // Short line: geometry error reported, run still completes, cleared on next start.
        expect_done(8'd1, 1'b0, 1'b1, img_seed, 1'b0, 32'd0);
        start_run(8'd1);
        frame(1'b1, 1, -1, -1);
        drain("geom_drain");
        start_run(8'd1);
        chk("geom_cleared", 64'(err_geom), 64'd0);
        expect_done(8'd1, 1'b0, 1'b0, img_seed, 1'b0, 32'd0);
        frame(1'b1, -1, -1, -1);
        drain("geom_ok_drain");

        // Continuous run stopped during frame 3; a following frame must not be captured.
        clr_counts();
        e_img = img_seed + 4'd2;
        expect_done(8'd3, 1'b0, 1'b0, e_img, 1'b0, 32'd0);
        start_run(8'd0);
        frame(1'b1, -1, -1, -1);
        frame(1'b1, -1, -1, -1);
        frame(1'b1, -1, 1, -1);
        frame(1'b0, -1, -1, -1);
        drain("stop_drain");
        chk("stop_valid", 64'(n_vld), 64'd96);
        chk("stop_fcnt", 64'(frame_cnt), 64'd3);
        chk("stop_done", 64'(n_done), 64'd1);
        chk("stop_sstart", 64'(sensor_start), 64'd0);

        // Reset mid-capture, then start+stop together in IDLE.
        start_run(8'd1);
        frame(1'b1, -1, -1, 1);
        drain("rst_drain");
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        tick();
        chk("start_stop_idle", 64'({busy, sensor_start, done}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
